// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI read-path arbiter.
// Round-robin grant, one outstanding burst, held from the AR handshake through
// the R beat carrying r_last. Flags a sticky burst-length mismatch.
module axi_rd_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3,
  parameter int DATA_BITS = 32
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  input  logic [1:0]             m_ar_valid,
  output logic [1:0]             m_ar_ready,
  input  logic [2*ADDR_BITS-1:0] m_ar_addr,
  input  logic [2*LEN_BITS-1:0]  m_ar_len,
  input  logic [2*SIZE_BITS-1:0] m_ar_size,
  input  logic [3:0]             m_ar_burst,
  output logic [DATA_BITS-1:0]   m_r_data,
  output logic [1:0]             m_r_resp,
  output logic                   m_r_last,
  output logic [1:0]             m_r_valid,
  input  logic [1:0]             m_r_ready,
  output logic                   s_ar_valid,
  input  logic                   s_ar_ready,
  output logic [ADDR_BITS-1:0]   s_ar_addr,
  output logic [LEN_BITS-1:0]    s_ar_len,
  output logic [SIZE_BITS-1:0]   s_ar_size,
  output logic [1:0]             s_ar_burst,
  input  logic [DATA_BITS-1:0]   s_r_data,
  input  logic [1:0]             s_r_resp,
  input  logic                   s_r_last,
  input  logic                   s_r_valid,
  output logic                   s_r_ready,
  output logic [1:0]             grant,
  output logic                   len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                ptr_q, ptr_d;       // master that wins a tie
  logic [LEN_BITS:0]   cnt_q, cnt_d;       // one extra bit so len=max never wraps
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                len_err_q, len_err_d;
  logic                gidx;               // index of the granted master
  logic                winner;
  logic                beat;

  assign gidx = grant_q[1];

  // Pick the requester: a lone request wins outright, a tie goes to the pointer.
  always_comb begin
    if (&m_ar_valid) winner = ptr_q;
    else             winner = m_ar_valid[1];
  end

  // AR fields follow the granted master's live inputs; R data is a plain broadcast.
  assign s_ar_addr  = gidx ? m_ar_addr[2*ADDR_BITS-1:ADDR_BITS] : m_ar_addr[ADDR_BITS-1:0];
  assign s_ar_len   = gidx ? m_ar_len[2*LEN_BITS-1:LEN_BITS]    : m_ar_len[LEN_BITS-1:0];
  assign s_ar_size  = gidx ? m_ar_size[2*SIZE_BITS-1:SIZE_BITS] : m_ar_size[SIZE_BITS-1:0];
  assign s_ar_burst = gidx ? m_ar_burst[3:2]                    : m_ar_burst[1:0];
  assign m_r_data   = s_r_data;
  assign m_r_resp   = s_r_resp;
  assign m_r_last   = s_r_last;
  assign grant      = grant_q;
  assign len_err    = len_err_q;

  // State and bookkeeping registers; reset aborts any burst in flight.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of the others.
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
    end
  end

  // Next-state logic and handshake routing for the granted master.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    len_err_d  = len_err_q;
    s_ar_valid = 1'b0;
    m_ar_ready = 2'b00;
    m_r_valid  = 2'b00;
    s_r_ready  = 1'b0;
    beat       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|m_ar_valid) begin
          grant_d = winner ? 2'b10 : 2'b01;
          len_d   = winner ? m_ar_len[2*LEN_BITS-1:LEN_BITS] : m_ar_len[LEN_BITS-1:0];
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_ar_valid       = 1'b1;
        m_ar_ready[gidx] = s_ar_ready;
        if (s_ar_ready) state_d = DATA;
      end
      DATA: begin
        m_r_valid[gidx] = s_r_valid;
        s_r_ready       = m_r_ready[gidx];
        beat            = s_r_valid & m_r_ready[gidx];
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          // Last flag early/late relative to the latched length.
          if ((s_r_last && cnt_q != {1'b0, len_q}) || (!s_r_last && cnt_q == {1'b0, len_q}))
            len_err_d = 1'b1;
          if (s_r_last) begin
            state_d = IDLE;
            grant_d = 2'b00;
            ptr_d   = ~gidx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
// Inputs change and outputs are sampled 1-2 time units after the rising edge.
module tb_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [1:0]  m_ar_valid;
  logic [1:0]  m_ar_ready;
  logic [63:0] m_ar_addr;
  logic [15:0] m_ar_len;
  logic [5:0]  m_ar_size;
  logic [3:0]  m_ar_burst;
  logic [31:0] m_r_data;
  logic [1:0]  m_r_resp;
  logic        m_r_last;
  logic [1:0]  m_r_valid;
  logic [1:0]  m_r_ready;
  logic        s_ar_valid;
  logic        s_ar_ready;
  logic [31:0] s_ar_addr;
  logic [7:0]  s_ar_len;
  logic [2:0]  s_ar_size;
  logic [1:0]  s_ar_burst;
  logic [31:0] s_r_data;
  logic [1:0]  s_r_resp;
  logic        s_r_last;
  logic        s_r_valid;
  logic        s_r_ready;
  logic [1:0]  grant;
  logic        len_err;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  axi_rd_arbiter dut (
    .aclk(aclk), .areset_n(areset_n),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .grant(grant), .len_err(len_err)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Request on master m; checks the one-cycle AR latency, the AR mux and the handshake.
  task automatic issue_ar(input int m, input logic [31:0] addr, input logic [7:0] len);
    logic [1:0] exp_g;
    exp_g = 2'b01 << m;
    m_ar_addr[m*32 +: 32] = addr;
    m_ar_len[m*8 +: 8]    = len;
    m_ar_size[m*3 +: 3]   = 3'd2;
    m_ar_burst[m*2 +: 2]  = 2'b01;
    m_ar_valid[m]         = 1'b1;
    s_ar_ready            = 1'b1;
    #1;
    checks++; if (s_ar_valid !== 1'b0 || grant !== 2'b00)
      begin errors++; $display("FAIL ar_latency_m%0d: s_ar_valid=%b grant=%b, want 0/00", m, s_ar_valid, grant); end
    tick();
    checks++; if (grant !== exp_g || s_ar_valid !== 1'b1 || m_ar_ready !== exp_g)
      begin errors++; $display("FAIL ar_grant_m%0d: grant=%b s_ar_valid=%b m_ar_ready=%b, want %b/1/%b", m, grant, s_ar_valid, m_ar_ready, exp_g, exp_g); end
    checks++; if (s_ar_addr !== addr || s_ar_len !== len || s_ar_size !== 3'd2 || s_ar_burst !== 2'b01)
      begin errors++; $display("FAIL ar_fields_m%0d: addr=%h len=%0d size=%0d burst=%0d, want %h/%0d/2/1", m, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, addr, len); end
    tick();
    m_ar_valid[m] = 1'b0;
    #1;
    checks++; if (s_ar_valid !== 1'b0 || grant !== exp_g)
      begin errors++; $display("FAIL ar_done_m%0d: s_ar_valid=%b grant=%b, want 0/%b", m, s_ar_valid, grant, exp_g); end
  endtask

  // Slave returns nbeats beats (data base+b) with r_last on beat index last_idx.
  task automatic serve_burst(input int m, input int nbeats, input int last_idx, input logic [31:0] base);
    logic [1:0] exp_v;
    exp_v = 2'b01 << m;
    m_r_ready = 2'b11;
    for (int b = 0; b < nbeats; b++) begin
      s_r_valid = 1'b1;
      s_r_data  = base + b;
      s_r_last  = (b == last_idx);
      #1;
      checks++; if (m_r_valid !== exp_v || s_r_ready !== 1'b1 || m_r_data !== base + b || m_r_last !== (b == last_idx))
        begin errors++; $display("FAIL r_beat_m%0d_b%0d: valid=%b ready=%b data=%h last=%b, want %b/1/%h/%b", m, b, m_r_valid, s_r_ready, m_r_data, m_r_last, exp_v, base + b, b == last_idx); end
      tick();
    end
    s_r_valid = 1'b0;
    s_r_last  = 1'b0;
    #1;
    checks++; if (grant !== 2'b00)
      begin errors++; $display("FAIL release_m%0d: grant=%b, want 00", m, grant); end
  endtask

  task automatic test_reset();
    areset_n   = 1'b0;
    m_ar_valid = 2'b00; m_ar_addr = '0; m_ar_len = '0; m_ar_size = '0; m_ar_burst = '0;
    m_r_ready  = 2'b00; s_ar_ready = 1'b0;
    s_r_data   = '0; s_r_resp = 2'b00; s_r_last = 1'b0; s_r_valid = 1'b0;
    tick(); tick();
    checks++; if (grant !== 2'b00 || s_ar_valid !== 1'b0 || m_ar_ready !== 2'b00 || m_r_valid !== 2'b00 || s_r_ready !== 1'b0 || len_err !== 1'b0)
      begin errors++; $display("FAIL reset_state: grant=%b sarv=%b marr=%b mrv=%b srr=%b lerr=%b, want all 0", grant, s_ar_valid, m_ar_ready, m_r_valid, s_r_ready, len_err); end
    areset_n = 1'b1;
    // Stray slave data while idle must not be accepted.
    s_r_valid = 1'b1;
    m_r_ready = 2'b11;
    #1;
    checks++; if (s_r_ready !== 1'b0 || m_r_valid !== 2'b00)
      begin errors++; $display("FAIL stray_r_idle: s_r_ready=%b m_r_valid=%b, want 0/00", s_r_ready, m_r_valid); end
    s_r_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    issue_ar(0, 32'h10, 8'd3);
    serve_burst(0, 4, 3, 32'hA0);
    checks++; if (len_err !== 1'b0)
      begin errors++; $display("FAIL single_len_err: len_err=%b, want 0", len_err); end
  endtask

  task automatic test_simultaneous();
    areset_n = 1'b0; tick(); areset_n = 1'b1;
    m_ar_addr = {32'h200, 32'h100};
    m_ar_len  = 16'h0000;
    m_ar_size = {3'd2, 3'd2}; m_ar_burst = 4'b0101;
    m_ar_valid = 2'b11;
    s_ar_ready = 1'b1;
    tick();
    checks++; if (grant !== 2'b01 || s_ar_addr !== 32'h100 || m_ar_ready !== 2'b01)
      begin errors++; $display("FAIL simul_first: grant=%b addr=%h m_ar_ready=%b, want 01/100/01", grant, s_ar_addr, m_ar_ready); end
    tick();
    m_ar_valid[0] = 1'b0;
    #1;
    checks++; if (s_ar_valid !== 1'b0 || m_ar_ready !== 2'b00)
      begin errors++; $display("FAIL simul_m1_waits: s_ar_valid=%b m_ar_ready=%b, want 0/00", s_ar_valid, m_ar_ready); end
    serve_burst(0, 1, 0, 32'hB0);
    tick();
    checks++; if (grant !== 2'b10 || s_ar_valid !== 1'b1 || s_ar_addr !== 32'h200)
      begin errors++; $display("FAIL simul_second: grant=%b sarv=%b addr=%h, want 10/1/200", grant, s_ar_valid, s_ar_addr); end
    tick();
    m_ar_valid[1] = 1'b0;
    serve_burst(1, 1, 0, 32'hC0);
  endtask

  task automatic test_fairness();
    logic [1:0] exp_order [4];
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    m_ar_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (grant !== exp_order[k])
        begin errors++; $display("FAIL fair_burst%0d: grant=%b, want %b", k, grant, exp_order[k]); end
      tick();
      serve_burst(exp_order[k] == 2'b10 ? 1 : 0, 1, 0, 32'hD0 + 32'(k));
    end
    m_ar_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    issue_ar(1, 32'h300, 8'd1);
    s_r_valid = 1'b1; s_r_data = 32'h55; s_r_last = 1'b0;
    m_r_ready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (s_r_ready !== 1'b0 || m_r_valid !== 2'b10)
        begin errors++; $display("FAIL bp_stall%0d: s_r_ready=%b m_r_valid=%b, want 0/10", c, s_r_ready, m_r_valid); end
      tick();
    end
    m_r_ready = 2'b10;
    #1;
    checks++; if (s_r_ready !== 1'b1 || m_r_data !== 32'h55 || m_r_last !== 1'b0)
      begin errors++; $display("FAIL bp_beat0: ready=%b data=%h last=%b, want 1/55/0", s_r_ready, m_r_data, m_r_last); end
    tick();
    s_r_data = 32'h66; s_r_last = 1'b1;
    #1;
    checks++; if (s_r_ready !== 1'b1 || m_r_data !== 32'h66 || m_r_last !== 1'b1 || grant !== 2'b10)
      begin errors++; $display("FAIL bp_beat1: ready=%b data=%h last=%b grant=%b, want 1/66/1/10", s_r_ready, m_r_data, m_r_last, grant); end
    tick();
    s_r_valid = 1'b0; s_r_last = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || len_err !== 1'b0)
      begin errors++; $display("FAIL bp_end: grant=%b len_err=%b, want 00/0", grant, len_err); end
  endtask

  task automatic test_len_err();
    issue_ar(0, 32'h400, 8'd2);
    m_r_ready = 2'b11;
    s_r_valid = 1'b1; s_r_data = 32'h1; s_r_last = 1'b0;
    tick();
    s_r_data = 32'h2; s_r_last = 1'b1;
    #1;
    checks++; if (len_err !== 1'b0)
      begin errors++; $display("FAIL len_err_early: len_err=%b, want 0", len_err); end
    tick();
    s_r_valid = 1'b0; s_r_last = 1'b0;
    #1;
    checks++; if (len_err !== 1'b1 || grant !== 2'b00)
      begin errors++; $display("FAIL len_err_set: len_err=%b grant=%b, want 1/00", len_err, grant); end
    issue_ar(1, 32'h480, 8'd0);
    serve_burst(1, 1, 0, 32'hE0);
    checks++; if (len_err !== 1'b1)
      begin errors++; $display("FAIL len_err_sticky: len_err=%b, want 1", len_err); end
  endtask

  task automatic test_reset_in_data();
    issue_ar(1, 32'h500, 8'd3);
    m_r_ready = 2'b11;
    s_r_valid = 1'b1; s_r_data = 32'h77; s_r_last = 1'b0;
    tick();
    m_ar_valid = 2'b01;
    m_ar_addr[31:0] = 32'h600; m_ar_len[7:0] = 8'd1;
    areset_n = 1'b0;
    #1;
    checks++; if (m_r_valid !== 2'b00 || s_r_ready !== 1'b0 || grant !== 2'b00 || s_ar_valid !== 1'b0 || m_ar_ready !== 2'b00 || len_err !== 1'b0)
      begin errors++; $display("FAIL reset_mid_burst: mrv=%b srr=%b grant=%b sarv=%b marr=%b lerr=%b, want all 0", m_r_valid, s_r_ready, grant, s_ar_valid, m_ar_ready, len_err); end
    s_r_valid = 1'b0;
    tick();
    areset_n = 1'b1;
    issue_ar(0, 32'h600, 8'd1);
    serve_burst(0, 2, 1, 32'hF0);
    checks++; if (len_err !== 1'b0)
      begin errors++; $display("FAIL post_reset_clean: len_err=%b, want 0", len_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_len_err();
    test_reset_in_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
